// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - EX-stage handshake bundle between the pipeline and the RV32M sequencer
//
// Purpose: groups the request, flush, stall and result signals exchanged
//          between the EX stage (master) and mdu_seq (slave).
// Signals:
//   start   request, sampled by the sequencer only while idle
//   mdu_op  RV32M funct3 (MUL..REMU)
//   rD1_ex  rs1 operand (multiplicand / dividend)
//   rD2_ex  rs2 operand (multiplier / divisor)
//   flush   abort the current operation
//   stall   hold IF/ID/EX pipeline registers (combinational)
//   done    one-cycle pulse, mdu_c valid while high
//   mdu_c   result register
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      mdu_op;
  logic [XLEN-1:0] rD1_ex;
  logic [XLEN-1:0] rD2_ex;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] mdu_c;

  modport master (
    output start, mdu_op, rD1_ex, rD2_ex, flush,
    input  stall, done, mdu_c
  );

  modport slave (
    input  start, mdu_op, rD1_ex, rD2_ex, flush,
    output stall, done, mdu_c
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
//
// Purpose: runs one M-extension operation as XLEN shift-add multiply steps or
//          XLEN restoring-divide steps, stalling the pipeline while busy and
//          pulsing done for one cycle with the result in mdu_c.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    mdu_seq_if.slave: start, mdu_op, rD1_ex, rD2_ex, flush (in);
//          stall, done, mdu_c (out)
// Configuration:
//   MDU_FAST_PATH_EN  when defined, divide-by-zero, DIV overflow and a multiply
//                     with a zero operand go straight from IDLE to FIN.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  mdu_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  // Multiply: a = multiplicand magnitude, b = multiplier shifting right.
  // Divide:   a = divisor magnitude, b = dividend shifting left, collecting quotient bits.
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  // Multiply: full product. Divide: upper half is the partial remainder.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              ovr_q, ovr_d;
  logic [XLEN-1:0]   ovr_val_q, ovr_val_d;
  logic [XLEN-1:0]   mdu_c_q, mdu_c_d;

  // Request decode from the live EX operands
  logic            sgn1, sgn2, s1, s2, div0, ovf, neg_req;
  logic [XLEN-1:0] mag1, mag2, ovr_val_req;
  logic [XLEN-1:0] min_val;

  assign min_val = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (bus.mdu_op)
      3'b001:         begin sgn1 = 1'b1; sgn2 = 1'b1; end  // MULH
      3'b010:         begin sgn1 = 1'b1; end               // MULHSU: rs2 unsigned
      3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end  // DIV, REM
      default:        ;
    endcase
    s1   = sgn1 & bus.rD1_ex[XLEN-1];
    s2   = sgn2 & bus.rD2_ex[XLEN-1];
    mag1 = s1 ? (~bus.rD1_ex + 1'b1) : bus.rD1_ex;
    mag2 = s2 ? (~bus.rD2_ex + 1'b1) : bus.rD2_ex;
    div0 = bus.mdu_op[2] & (bus.rD2_ex == '0);
    ovf  = bus.mdu_op[2] & ~bus.mdu_op[0] & (bus.rD1_ex == min_val) & (bus.rD2_ex == '1);
    // Remainder follows the dividend sign; everything else takes the XOR.
    neg_req = (bus.mdu_op[2] & bus.mdu_op[1]) ? s1 : (s1 ^ s2);
    if (div0) begin
      ovr_val_req = bus.mdu_op[1] ? bus.rD1_ex : '1;
    end else begin
      ovr_val_req = bus.mdu_op[1] ? '0 : min_val;
    end
  end

`ifdef MDU_FAST_PATH_EN
  logic mul_zero;
  assign mul_zero = ~bus.mdu_op[2] & ((bus.rD1_ex == '0) | (bus.rD2_ex == '0));
`endif

  // One iteration step
  logic [XLEN:0] mul_sum, div_trial, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_trial = {acc_q[2*XLEN-1:XLEN], b_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, a_q};
  end

  // Sign fix-up and result selection for FIN
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~b_q + 1'b1) : b_q;
    rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo_fix;
      default:                fin_res = rem_fix;
    endcase
    if (ovr_q) begin
      fin_res = ovr_val_q;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    ovr_d     = ovr_q;
    ovr_val_d = ovr_val_q;
    mdu_c_d   = mdu_c_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d      = bus.mdu_op;
          a_d       = bus.mdu_op[2] ? mag2 : mag1;
          b_d       = bus.mdu_op[2] ? mag1 : mag2;
          acc_d     = '0;
          cnt_d     = '0;
          neg_d     = neg_req;
          ovr_d     = div0 | ovf;
          ovr_val_d = ovr_val_req;
`ifdef MDU_FAST_PATH_EN
          state_d   = (div0 || ovf || mul_zero) ? FIN : CALC;
`else
          state_d   = CALC;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[2]) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          b_d   = b_q >> 1;
        end else if (!div_diff[XLEN]) begin
          acc_d[2*XLEN-1:XLEN] = div_diff[XLEN-1:0];
          b_d                  = {b_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d[2*XLEN-1:XLEN] = div_trial[XLEN-1:0];
          b_d                  = {b_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        mdu_c_d = fin_res;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush discards the operation and must not disturb the visible result.
    if (bus.flush) begin
      state_d = IDLE;
      mdu_c_d = mdu_c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_val_q <= '0;
      mdu_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      ovr_q     <= ovr_d;
      ovr_val_q <= ovr_val_d;
      mdu_c_q   <= mdu_c_d;
    end
  end

  assign bus.stall = ((state_q == IDLE) & bus.start & ~bus.flush)
                   | (state_q == CALC) | (state_q == FIN);
  assign bus.done  = (state_q == DONE);
  assign bus.mdu_c = mdu_c_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking scoreboard bench for mdu_seq
module tb_mdu_seq;

  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 2;
`ifdef MDU_FAST_PATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_seq_if #(.XLEN(XLEN)) bus ();

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic        [63:0] ua, ub, up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = (op[2] && b == 0)
        || (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        || (!op[2] && (a == 0 || b == 0));
    return (FAST_EN && fast) ? 2 : LAT_FULL;
  endfunction

  // Issue one operation, then follow it to done and score it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string tag);
    exp_t e;
    int   lat;
    int   stl;
    bit   seen;
    e.res = exp_res;
    e.lat = exp_lat(op, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rD1_ex = a;
    bus.rD2_ex = b;
    #1;
    stl  = bus.stall ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.stall) stl++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_res"}, bus.mdu_c, e.res);
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_stall_cycles"}, stl, e.lat);
      check({tag, "_stall_in_done"}, bus.stall, 1'b0);
      last_c = e.res;
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 1'b0);
      check({tag, "_hold"}, bus.mdu_c, e.res);
    end
  endtask

  int done_cnt;

  initial begin
    bus.start  = 1'b0;
    bus.mdu_op = 3'b000;
    bus.rD1_ex = '0;
    bus.rD2_ex = '0;
    bus.flush  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", bus.stall, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_mdu_c", bus.mdu_c, 32'h0);
    rst_n  = 1'b1;
    last_c = 32'h0;

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh");
    run_op(3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div");
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem");
    run_op(3'b101, 32'd100,        32'd7,         32'd14,        "divu");
    run_op(3'b111, 32'd100,        32'd7,         32'd2,         "remu");
    run_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_op(3'b110, 32'd5,          32'd0,         32'd5,         "rem_by0");
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf");
    run_op(3'b000, 32'h0,          32'h1234_5678, 32'h0,         "mul_zero");

    // Flush 10 cycles into CALC
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'b101; bus.rD1_ex = 32'd1000; bus.rD2_ex = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_stall", bus.stall, 1'b0);
    check("flush_done", bus.done, 1'b0);
    check("flush_mdu_c", bus.mdu_c, last_c);
    run_op(3'b101, 32'd1000, 32'd3, 32'd333, "after_flush");

    // Reset pulse mid-CALC
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 3'b001; bus.rD1_ex = 32'h1234_5678; bus.rD2_ex = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_stall", bus.stall, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);
    check("rst_mid_mdu_c", bus.mdu_c, 32'h0);
    last_c   = 32'h0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("rst_mid_no_done", done_cnt, 0);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.mdu_op = 3'b011; bus.rD1_ex = 32'd9; bus.rD2_ex = 32'd9;
    #1;
    check("startflush_stall_req", bus.stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("startflush_idle", bus.stall, 1'b0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("startflush_no_done", done_cnt, 0);
    check("startflush_mdu_c", bus.mdu_c, last_c);

    // Random operations scored against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op(op, a, b, model(op, a, b), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
